// File: rtl/sim_completion_monitor.sv
`default_nettype none
// ============================================================================
// Module  : sim_completion_monitor
// Brief   : Holds harness reset, counts run cycles and latches a sticky pass/fail
//           verdict from N success/failure channels. Optional watchdog is
//           enabled by defining SIM_MONITOR_WATCHDOG_EN.
// Revision: 1.0  initial release
// ============================================================================
module sim_completion_monitor #(
  parameter int NUM_CHANNELS = 4,
  parameter int CYCLE_WIDTH  = 64,
  parameter int RESET_CYCLES = 16,
  parameter bit PASS_ALL     = 1'b1
`ifdef SIM_MONITOR_WATCHDOG_EN
  ,
  parameter int WATCHDOG_CYCLES = 100000
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CYCLE_WIDTH-1:0]  max_cycles,
  input  logic [CYCLE_WIDTH-1:0]  dump_start,
  input  logic [NUM_CHANNELS-1:0] chan_success,
  input  logic [NUM_CHANNELS-1:0] chan_failure,
`ifdef SIM_MONITOR_WATCHDOG_EN
  input  logic                    heartbeat,
`endif
  output logic                    dut_reset,
  output logic                    dump_enable,
  output logic [CYCLE_WIDTH-1:0]  cycle_count,
  output logic [NUM_CHANNELS-1:0] success_seen,
  output logic                    done,
  output logic                    passed,
  output logic [1:0]              fail_code,
  output logic [4:0]              fail_chan
);

  localparam int                      c_hold_w    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [c_hold_w-1:0]     c_hold_last = c_hold_w'(RESET_CYCLES - 1);
  localparam logic [c_hold_w-1:0]     c_hold_one  = c_hold_w'(1);
  localparam logic [CYCLE_WIDTH-1:0]  c_cyc_one   = CYCLE_WIDTH'(1);
  localparam logic [NUM_CHANNELS-1:0] c_all_ones  = '1;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [c_hold_w-1:0]     hold_cnt_q, hold_cnt_d;
  logic                    dut_reset_q, dut_reset_d;
  logic                    dump_enable_q, dump_enable_d;
  logic [CYCLE_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [NUM_CHANNELS-1:0] success_seen_q, success_seen_d;
  logic                    done_q, done_d;
  logic                    passed_q, passed_d;
  logic [1:0]              fail_code_q, fail_code_d;
  logic [4:0]              fail_chan_q, fail_chan_d;

  logic [CYCLE_WIDTH-1:0]  cnt_next;
  logic [NUM_CHANNELS-1:0] seen_next;
  logic [4:0]              fail_idx;
  logic                    timeout_hit;
  logic                    pass_hit;
  logic                    wd_trip;

  assign cnt_next    = (&cycle_count_q) ? cycle_count_q : cycle_count_q + c_cyc_one;
  assign seen_next   = success_seen_q | chan_success;
  assign timeout_hit = (|max_cycles) && (cycle_count_q > max_cycles);
  assign pass_hit    = PASS_ALL ? (seen_next == c_all_ones) : (|seen_next);

  always_comb begin
    fail_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (chan_failure[i]) fail_idx = 5'(i);
    end
  end

`ifdef SIM_MONITOR_WATCHDOG_EN
  // Heartbeat counter restarts on any toggle of heartbeat and only runs in RUN.
  logic [31:0] wd_cnt_q, wd_cnt_d, wd_next;
  logic        hb_prev_q, hb_prev_d;

  assign wd_next   = (heartbeat != hb_prev_q) ? 32'd0 : wd_cnt_q + 32'd1;
  assign wd_trip   = (wd_next >= 32'(WATCHDOG_CYCLES));
  assign wd_cnt_d  = (state_q == S_RUN) ? wd_next : 32'd0;
  assign hb_prev_d = heartbeat;
`else
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    dut_reset_d    = dut_reset_q;
    dump_enable_d  = dump_enable_q;
    cycle_count_d  = cycle_count_q;
    success_seen_d = success_seen_q;
    done_d         = done_q;
    passed_d       = passed_q;
    fail_code_d    = fail_code_q;
    fail_chan_d    = fail_chan_q;
    case (state_q)
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + c_hold_one;
        if (hold_cnt_q == c_hold_last) begin
          state_d       = S_RUN;
          dut_reset_d   = 1'b0;
          cycle_count_d = c_cyc_one;
          if (dump_start == c_cyc_one) dump_enable_d = 1'b1;
        end
      end
      S_RUN: begin
        success_seen_d = seen_next;
        if (|chan_failure) begin
          state_d     = S_FAIL;
          fail_code_d = 2'd1;
          fail_chan_d = fail_idx;
        end else if (timeout_hit) begin
          state_d     = S_FAIL;
          fail_code_d = 2'd2;
        end else if (wd_trip) begin
          state_d     = S_FAIL;
          fail_code_d = 2'd3;
        end else if (pass_hit) begin
          state_d  = S_PASS;
          passed_d = 1'b1;
        end else begin
          // Count shown next cycle is the one compared against dump_start.
          cycle_count_d = cnt_next;
          if (cnt_next == dump_start) dump_enable_d = 1'b1;
        end
        if (state_d != S_RUN) begin
          done_d        = 1'b1;
          dump_enable_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_HOLD;
      hold_cnt_q     <= '0;
      dut_reset_q    <= 1'b1;
      dump_enable_q  <= ~|dump_start;
      cycle_count_q  <= '0;
      success_seen_q <= '0;
      done_q         <= 1'b0;
      passed_q       <= 1'b0;
      fail_code_q    <= 2'd0;
      fail_chan_q    <= 5'd0;
`ifdef SIM_MONITOR_WATCHDOG_EN
      wd_cnt_q       <= 32'd0;
      hb_prev_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      dut_reset_q    <= dut_reset_d;
      dump_enable_q  <= dump_enable_d;
      cycle_count_q  <= cycle_count_d;
      success_seen_q <= success_seen_d;
      done_q         <= done_d;
      passed_q       <= passed_d;
      fail_code_q    <= fail_code_d;
      fail_chan_q    <= fail_chan_d;
`ifdef SIM_MONITOR_WATCHDOG_EN
      wd_cnt_q       <= wd_cnt_d;
      hb_prev_q      <= hb_prev_d;
`endif
    end
  end

  assign dut_reset    = dut_reset_q;
  assign dump_enable  = dump_enable_q;
  assign cycle_count  = cycle_count_q;
  assign success_seen = success_seen_q;
  assign done         = done_q;
  assign passed       = passed_q;
  assign fail_code    = fail_code_q;
  assign fail_chan    = fail_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_completion_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_sim_completion_monitor
// Brief   : Scenario-driven bench for sim_completion_monitor (all-pass, any-pass
//           and a narrow saturating instance) against a verdict-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_sim_completion_monitor;

  localparam int N    = 4;
  localparam int CW   = 64;
  localparam int RC   = 16;
  localparam int MAXG = 127;

  typedef struct packed {
    logic        dut_reset;
    logic        dump_enable;
    logic [63:0] cycle_count;
    logic [3:0]  success_seen;
    logic        done;
    logic        passed;
    logic [1:0]  fail_code;
    logic [4:0]  fail_chan;
  } obs_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] max_cycles = '0;
  logic [CW-1:0] dump_start = '0;
  logic [N-1:0]  chan_success = '0;
  logic [N-1:0]  chan_failure = '0;
  logic          sat_success = 1'b0;

  logic a_dut_reset, a_dump_enable, a_done, a_passed;
  logic [CW-1:0] a_cycle_count;
  logic [N-1:0]  a_success_seen;
  logic [1:0]    a_fail_code;
  logic [4:0]    a_fail_chan;
  logic b_dut_reset, b_dump_enable, b_done, b_passed;
  logic [CW-1:0] b_cycle_count;
  logic [N-1:0]  b_success_seen;
  logic [1:0]    b_fail_code;
  logic [4:0]    b_fail_chan;
  logic s_dut_reset, s_dump_enable, s_done, s_passed, s_success_seen;
  logic [3:0]    s_cycle_count;
  logic [1:0]    s_fail_code;
  logic [4:0]    s_fail_chan;

  sim_completion_monitor #(.NUM_CHANNELS(N), .CYCLE_WIDTH(CW), .RESET_CYCLES(RC), .PASS_ALL(1'b1)) u_all (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .dump_start(dump_start),
    .chan_success(chan_success), .chan_failure(chan_failure),
    .dut_reset(a_dut_reset), .dump_enable(a_dump_enable), .cycle_count(a_cycle_count),
    .success_seen(a_success_seen), .done(a_done), .passed(a_passed),
    .fail_code(a_fail_code), .fail_chan(a_fail_chan));

  sim_completion_monitor #(.NUM_CHANNELS(N), .CYCLE_WIDTH(CW), .RESET_CYCLES(RC), .PASS_ALL(1'b0)) u_any (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .dump_start(dump_start),
    .chan_success(chan_success), .chan_failure(chan_failure),
    .dut_reset(b_dut_reset), .dump_enable(b_dump_enable), .cycle_count(b_cycle_count),
    .success_seen(b_success_seen), .done(b_done), .passed(b_passed),
    .fail_code(b_fail_code), .fail_chan(b_fail_chan));

  sim_completion_monitor #(.NUM_CHANNELS(1), .CYCLE_WIDTH(4), .RESET_CYCLES(1), .PASS_ALL(1'b0)) u_sat (
    .clock(clock), .reset(reset), .max_cycles(4'h0), .dump_start(4'h0),
    .chan_success(sat_success), .chan_failure(1'b0),
    .dut_reset(s_dut_reset), .dump_enable(s_dump_enable), .cycle_count(s_cycle_count),
    .success_seen(s_success_seen), .done(s_done), .passed(s_passed),
    .fail_code(s_fail_code), .fail_chan(s_fail_chan));

  always #5 clock = ~clock;

  logic [N-1:0] succ_v [0:MAXG];
  logic [N-1:0] fail_v [0:MAXG];
  logic         sat_v  [0:MAXG];
  int           L;
  int           vectors = 0;
  int           miscompares = 0;

  function automatic obs_t obs_all();
    return {a_dut_reset, a_dump_enable, a_cycle_count, a_success_seen, a_done, a_passed, a_fail_code, a_fail_chan};
  endfunction
  function automatic obs_t obs_any();
    return {b_dut_reset, b_dump_enable, b_cycle_count, b_success_seen, b_done, b_passed, b_fail_code, b_fail_chan};
  endfunction
  function automatic obs_t obs_sat();
    return {s_dut_reset, s_dump_enable, 60'd0, s_cycle_count, 3'd0, s_success_seen, s_done, s_passed, s_fail_code, s_fail_chan};
  endfunction

  task automatic chk(input string tag, input obs_t obs, input obs_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // First run cycle at which a verdict is reached, by the stated priority rules.
  task automatic find_verdict(input bit pall, output int v, output int code, output int fch);
    logic [N-1:0] seen;
    seen = '0; v = 0; code = 0; fch = 0;
    for (int n = 1; n <= L; n++) begin
      seen = seen | succ_v[n];
      if (fail_v[n] != '0) begin
        v = n; code = 1;
        while (!fail_v[n][fch]) fch++;
        return;
      end
      if (max_cycles != 0 && 64'(n) > max_cycles) begin v = n; code = 2; return; end
      if (pall ? (&seen) : (|seen)) begin v = n; code = 0; return; end
    end
  endtask

  function automatic obs_t exp_main(int n, int v, int code, int fch);
    obs_t         e;
    logic [N-1:0] seen;
    e = '0; seen = '0;
    if (n == 0) begin
      e.dut_reset   = 1'b1;
      e.dump_enable = (dump_start == 0);
      return e;
    end
    if (v == 0 || n <= v) begin
      for (int k = 1; k < n; k++) seen = seen | succ_v[k];
      e.cycle_count = 64'(n);
      e.dump_enable = (dump_start == 0) || (dump_start <= 64'(n));
    end else begin
      for (int k = 1; k <= v; k++) seen = seen | succ_v[k];
      e.cycle_count = 64'(v);
      e.done        = 1'b1;
      e.passed      = (code == 0);
      e.fail_code   = 2'(code);
      e.fail_chan   = 5'(fch);
    end
    e.success_seen = seen;
    return e;
  endfunction

  function automatic obs_t exp_sat(int g, int vs);
    obs_t e;
    int   n;
    e = '0;
    if (g <= 1) begin
      e.dut_reset   = 1'b1;
      e.dump_enable = 1'b1;
      return e;
    end
    n = g - 1;
    if (vs == 0 || n <= vs) begin
      e.cycle_count = 64'((n > 15) ? 15 : n);
      e.dump_enable = 1'b1;
    end else begin
      e.cycle_count  = 64'((vs > 15) ? 15 : vs);
      e.success_seen = 4'b0001;
      e.done         = 1'b1;
      e.passed       = 1'b1;
    end
    return e;
  endfunction

  task automatic new_scn(input int len, input logic [63:0] mc, input logic [63:0] ds);
    L = len; max_cycles = mc; dump_start = ds;
    for (int i = 0; i <= MAXG; i++) begin
      succ_v[i] = '0; fail_v[i] = '0; sat_v[i] = 1'b0;
    end
  endtask

  task automatic run_scenario(input string name);
    int va, ca, fa, vb, cb, fb, vs, gtot, n;
    gtot = RC + L;
    find_verdict(1'b1, va, ca, fa);
    find_verdict(1'b0, vb, cb, fb);
    vs = 0;
    for (int g = 2; g <= gtot; g++) if (vs == 0 && sat_v[g]) vs = g - 1;
    reset = 1'b1; chan_success = '0; chan_failure = '0; sat_success = 1'b0;
    tick(); tick();
    @(negedge clock);
    chk({name, " all reset"}, obs_all(), exp_main(0, va, ca, fa));
    chk({name, " any reset"}, obs_any(), exp_main(0, vb, cb, fb));
    chk({name, " sat reset"}, obs_sat(), exp_sat(0, vs));
    @(posedge clock); #1;
    reset = 1'b0;
    for (int g = 1; g <= gtot; g++) begin
      n = g - RC;
      if (n >= 1) begin
        chan_success = succ_v[n]; chan_failure = fail_v[n];
      end else begin
        chan_success = 4'($urandom); chan_failure = 4'($urandom);
      end
      sat_success = sat_v[g];
      @(negedge clock);
      chk($sformatf("%s all g=%0d", name, g), obs_all(), exp_main((n < 1) ? 0 : n, va, ca, fa));
      chk($sformatf("%s any g=%0d", name, g), obs_any(), exp_main((n < 1) ? 0 : n, vb, cb, fb));
      chk($sformatf("%s sat g=%0d", name, g), obs_sat(), exp_sat(g, vs));
      @(posedge clock); #1;
    end
  endtask

  initial begin
    // All channels report in turn; last report completes the all-pass verdict.
    new_scn(45, 64'd0, 64'd0);
    succ_v[10] = 4'b0001; succ_v[20] = 4'b0010; succ_v[30] = 4'b0100; succ_v[40] = 4'b1000;
    run_scenario("pass_all");
    chk("pass_all final", obs_all(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd40,
        success_seen:4'hF, done:1'b1, passed:1'b1, fail_code:2'd0, fail_chan:5'd0});

    new_scn(10, 64'd0, 64'd0);
    succ_v[5] = 4'b0100;
    run_scenario("any_first");
    chk("any_first final", obs_any(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd5,
        success_seen:4'b0100, done:1'b1, passed:1'b1, fail_code:2'd0, fail_chan:5'd0});

    new_scn(104, 64'd100, 64'd7);
    run_scenario("timeout");
    chk("timeout final", obs_all(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd101,
        success_seen:4'h0, done:1'b1, passed:1'b0, fail_code:2'd2, fail_chan:5'd0});

    new_scn(55, 64'd0, 64'd0);
    succ_v[10] = 4'b0001; succ_v[20] = 4'b0010; succ_v[30] = 4'b0100;
    succ_v[50] = 4'b1000; fail_v[50] = 4'b1010;
    run_scenario("fail_over_pass");
    chk("fail_over_pass final", obs_all(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd50,
        success_seen:4'hF, done:1'b1, passed:1'b0, fail_code:2'd1, fail_chan:5'd1});

    new_scn(64, 64'd0, 64'd25);
    succ_v[10] = 4'b0001; succ_v[20] = 4'b0010; succ_v[30] = 4'b0100; succ_v[60] = 4'b1000;
    run_scenario("dump_window");
    chk("dump_window final", obs_all(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd60,
        success_seen:4'hF, done:1'b1, passed:1'b1, fail_code:2'd0, fail_chan:5'd0});

    // Left mid-run for u_all; the next scenario's reset must clear it.
    new_scn(30, 64'd0, 64'd5);
    succ_v[12] = 4'b0001; succ_v[18] = 4'b0010; sat_v[40] = 1'b1;
    run_scenario("midrun");
    chk("sat final", obs_sat(), '{dut_reset:1'b0, dump_enable:1'b0, cycle_count:64'd15,
        success_seen:4'b0001, done:1'b1, passed:1'b1, fail_code:2'd0, fail_chan:5'd0});

    for (int s = 0; s < 20; s++) begin
      new_scn($urandom_range(20, 90),
              ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(15, 80)),
              ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 70)));
      for (int n = 1; n <= L; n++) begin
        succ_v[n] = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        fail_v[n] = ($urandom_range(0, 79) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
      for (int g = 1; g <= RC + L; g++) sat_v[g] = ($urandom_range(0, 119) == 0);
      run_scenario($sformatf("rand%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_completion_monitor.md
Name: sim_completion_monitor

Overview:
- Parametrised, synthesizable successor to the single-success test driver.
- Sequences DUT reset and counts run cycles.
- Watches N independent success/failure channels under a selectable pass policy, enforces a runtime cycle limit, and gates waveform dumping.
- Sits between the top-level testbench shell and one or more harness instances; reports a sticky, encoded final verdict the shell turns into $finish/$fatal.

Parameters:
- NUM_CHANNELS, 4, number of success/failure channel pairs (1..32).
- CYCLE_WIDTH, 64, width of the cycle counter, max_cycles and dump_start.
- RESET_CYCLES, 16, cycles dut_reset is held after the monitor leaves reset (>=1).
- PASS_ALL, 1, 1 = pass when every channel has reported success; 0 = pass on the first success from any channel.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- max_cycles  in  CYCLE_WIDTH  run-cycle limit; 0 disables timeout; sampled every cycle.
- dump_start  in  CYCLE_WIDTH  run cycle at which dumping begins; 0 = dump from start of reset hold.
- chan_success  in  NUM_CHANNELS  per-channel success pulse or level.
- chan_failure  in  NUM_CHANNELS  per-channel failure pulse or level.
- dut_reset  out  1  reset driven to harness instances.
- dump_enable  out  1  waveform dump gate.
- cycle_count  out  CYCLE_WIDTH  run cycles elapsed.
- success_seen  out  NUM_CHANNELS  sticky per-channel success flags.
- done  out  1  verdict valid, sticky.
- passed  out  1  1 = pass; valid when done.
- fail_code  out  2  0 none, 1 channel failure, 2 timeout, 3 watchdog.
- fail_chan  out  5  lowest-index failing channel when fail_code==1, else 0.

Behaviour:
- Reset values:
  - dut_reset=1.
  - dump_enable=(dump_start==0) sampled during reset.
  - cycle_count=0, success_seen=0, done=0, passed=0, fail_code=0, fail_chan=0.
  - State=HOLD.
- States: HOLD, RUN, PASS, FAIL. PASS and FAIL are terminal and left only by reset.
- HOLD:
  - An internal counter counts RESET_CYCLES clocks with dut_reset=1.
  - On the last count, go to RUN; dut_reset drops on the first RUN cycle.
  - Channel inputs are ignored in HOLD.
- RUN:
  - cycle_count increments by 1 every RUN cycle, saturating at all-ones.
  - First RUN cycle shows 1.
  - success_seen[i] is set on any RUN cycle with chan_success[i]=1 and never clears before reset.
- Evaluation each RUN cycle, using current inputs plus updated success_seen. Priority: failure > timeout > watchdog > pass.
  - Any chan_failure bit set: FAIL, fail_code=1, fail_chan = lowest set index.
  - Else if max_cycles!=0 and cycle_count(after increment) > max_cycles: FAIL, fail_code=2.
  - Else if watchdog trips (optional feature): FAIL, fail_code=3.
  - Else if PASS_ALL=1 and all success_seen bits set, or PASS_ALL=0 and any bit set: PASS.
- Verdict latency:
  - done, passed, fail_code and fail_chan update one cycle after the triggering input cycle (registered).
  - They then hold.
  - dut_reset stays 0 in terminal states.
  - cycle_count freezes at the triggering cycle's value.
- Dump gate:
  - dump_enable sets on the RUN cycle where cycle_count reaches dump_start.
  - dump_enable clears on the cycle done rises.
  - If dump_start is beyond the verdict cycle, dump_enable never asserts.
- Inputs in terminal states are ignored.
- Reset asserted mid-run returns all state to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: SIM_MONITOR_WATCHDOG_EN.
- When defined:
  - Adds parameter WATCHDOG_CYCLES (default 100000).
  - Adds input heartbeat (1 bit).
  - In RUN, a counter clears on any heartbeat edge (value differs from the previous cycle's value) and otherwise increments.
  - Reaching WATCHDOG_CYCLES causes FAIL with fail_code=3.
- When not defined: port and logic are absent, and fail_code 3 is never produced.

Test Plan:
- RESET_CYCLES=16, PASS_ALL=1, N=4, chan_success bits pulsed at run cycles 10,20,30,40 -> dut_reset low from cycle 17 after reset; done=1, passed=1 one cycle after the cycle-40 pulse; cycle_count=40.
- PASS_ALL=0, chan_success[2] at run cycle 5 -> passed=1; success_seen=4'b0100.
- max_cycles=100, no events -> fail_code=2 with cycle_count=101; done rises the next cycle.
- chan_failure=4'b1010 together with the final chan_success at cycle 50 -> fail_code=1, fail_chan=1, passed=0.
- dump_start=25, pass at run cycle 60 -> dump_enable high on cycles 25..60, low when done rises; dump_start=0 -> dump_enable high from reset.
- Reset asserted at run cycle 30, then released -> all outputs return to reset values and HOLD repeats; with SIM_MONITOR_WATCHDOG_EN, WATCHDOG_CYCLES=50 and heartbeat static -> fail_code=3 at run cycle 50.
